regfile_onehot_wr: RTL and testbench

- 32-entry x DATA_W register file whose write port is driven directly by the one-hot 32-bit select from the 5-to-32 write-address decoder.
- Sits downstream of that decoder.
- Provides two registered read ports, a hardwired-zero r0, and a sticky error flag for malformed (non-one-hot) write selects.
- Feeds ALU operand registers for the 32-bit datapath.

---
 rtl/regfile_onehot_wr.sv | 147 ++++++++++++++
 tb/tb_regfile_onehot_wr.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_onehot_wr.sv
// -----------------------------------------------------------------------------
// regfile_onehot_wr
//
// 32-entry x DATA_W register file. The write port takes the one-hot select
// straight from the upstream 5-to-32 write-address decoder. There are two
// registered read ports, r0 reads as zero, and a sticky error flag records any
// write request whose select is not exactly one-hot.
//
// Optional feature (compile-time macro REGFILE_BYPASS_EN):
//   defined     : a valid write to ri is forwarded to a read port that reads
//                 ri at the same edge (the port returns the new value).
//   not defined : the same-edge read returns the old contents of ri.
//   Writes aimed at r0 and malformed writes never forward.
//
// Parameters
//   DATA_W     width of each register and of the data buses
//   RESET_VAL  reset value for r1..r31 (r0 is always 0)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   wr_en      write request, sampled at rising clk
//   wr_sel     one-hot register select, bit i selects ri
//   wr_data    write data
//   rd_en      read request for both ports, sampled at rising clk
//   rd_addr_a  port A register index
//   rd_addr_b  port B register index
//   rd_data_a  registered read data, port A
//   rd_data_b  registered read data, port B
//   rd_valid   one-cycle pulse, rd_data_a/b were updated this cycle
//   sel_err    sticky flag, set by a write request with a non-one-hot wr_sel
//   clr_err    synchronous clear of sel_err (a same-edge new error wins)
//
// Read handshake: there is no back-pressure. A read is issued by holding
// rd_en high across a rising edge; exactly one cycle later rd_valid is high
// for one cycle and rd_data_a/b carry the result. Consecutive rd_en cycles
// give consecutive rd_valid cycles. Outside a valid pulse the data outputs
// hold the last read result.
// -----------------------------------------------------------------------------
module regfile_onehot_wr #(
  parameter int unsigned          DATA_W    = 32,
  parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [31:0]       wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [4:0]        rd_addr_a,
  input  logic [4:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid,
  output logic              sel_err,
  input  logic              clr_err
);

  // Storage exists only for r1..r31; r0 is a constant in the read view.
  logic [DATA_W-1:0] mem [1:31];
  logic [DATA_W-1:0] rf_view [0:31];

  logic        sel_onehot;
  logic        sel_bad;
  logic [31:0] wr_fire;
  logic [DATA_W-1:0] rd_next_a;
  logic [DATA_W-1:0] rd_next_b;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  always_comb begin
    sel_onehot = (wr_sel != 32'd0) && ((wr_sel & (wr_sel - 32'd1)) == 32'd0);
    sel_bad    = wr_en && !sel_onehot;
  end

  // Per-register write enables. Bit 0 is produced for completeness but no
  // storage consumes it, so r0 writes are dropped without raising an error.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      wr_fire[i] = wr_en && wr_sel[i] && sel_onehot;
    end
  end

  always_comb begin
    rf_view[0] = '0;
    for (int i = 1; i < 32; i++) begin
      rf_view[i] = mem[i];
    end
  end

  // Read-data selection. With forwarding, a same-edge valid write to the
  // addressed register overrides the stored value. wr_fire[0] is never
  // consulted because address 0 is forced to zero first.
  always_comb begin
    rd_next_a = rf_view[rd_addr_a];
    rd_next_b = rf_view[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
    if (rd_addr_a != 5'd0 && wr_fire[rd_addr_a]) begin
      rd_next_a = wr_data;
    end
    if (rd_addr_b != 5'd0 && wr_fire[rd_addr_b]) begin
      rd_next_b = wr_data;
    end
`endif
  end

  // Register array r1..r31.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) begin
        mem[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (wr_fire[i]) begin
          mem[i] <= wr_data;
        end
      end
    end
  end

  // Registered read ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data_a <= rd_next_a;
        rd_data_b <= rd_next_b;
      end
    end
  end

  // Sticky select error; a new error at the same edge beats the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else if (sel_bad) begin
      sel_err <= 1'b1;
    end else if (clr_err) begin
      sel_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// -----------------------------------------------------------------------------
// tb_regfile_onehot_wr
//
// Stimulus is driven on the falling edge. At the moment stimulus is issued a
// reference model (a plain array of 32 registers plus an error bit) computes
// the response for the coming rising edge and pushes any read result into
// exp_q. A separate monitor samples 1 ns after each rising edge, pops and
// compares whenever rd_valid is seen, and also checks rd_valid, data hold and
// sel_err every cycle.
// -----------------------------------------------------------------------------
module tb_regfile_onehot_wr;

  localparam int unsigned       DATA_W    = 32;
  localparam logic [DATA_W-1:0] RESET_VAL = '0;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic              wr_en;
  logic [31:0]       wr_sel;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [4:0]        rd_addr_a;
  logic [4:0]        rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_valid;
  logic              sel_err;
  logic              clr_err;

  regfile_onehot_wr #(
    .DATA_W    (DATA_W),
    .RESET_VAL (RESET_VAL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .rd_valid  (rd_valid),
    .sel_err   (sel_err),
    .clr_err   (clr_err)
  );

  // ---------------- scoreboard state ----------------
  logic [2*DATA_W-1:0] exp_q[$];     // {port A, port B}
  logic [DATA_W-1:0]   model_rf [32];
  logic                exp_err;
  logic                exp_valid;
  logic [DATA_W-1:0]   hold_a;
  logic [DATA_W-1:0]   hold_b;

  int n_cmp;
  int n_bad;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      model_rf[i] = (i == 0) ? '0 : RESET_VAL;
    end
    exp_err   = 1'b0;
    exp_valid = 1'b0;
    hold_a    = '0;
    hold_b    = '0;
    exp_q.delete();
  endtask

  // Value a read port should return for address addr at an edge that also
  // carries the given write request.
  function automatic logic [DATA_W-1:0] model_read(
      input logic [4:0] addr, input logic we, input logic [31:0] ws,
      input logic [DATA_W-1:0] wd);
    logic [DATA_W-1:0] v;
    v = (addr == 5'd0) ? '0 : model_rf[addr];
`ifdef REGFILE_BYPASS_EN
    if (addr != 5'd0 && we && $countones(ws) == 1 && ws[addr]) begin
      v = wd;
    end
`else
    if (we && ws == 32'hFFFF_FFFF && wd == '1) v = v; // no forwarding in this build
`endif
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic we, input logic [31:0] ws,
                       input logic [DATA_W-1:0] wd, input logic re,
                       input logic [4:0] aa, input logic [4:0] ab,
                       input logic ce);
    @(negedge clk);
    wr_en     = we;
    wr_sel    = ws;
    wr_data   = wd;
    rd_en     = re;
    rd_addr_a = aa;
    rd_addr_b = ab;
    clr_err   = ce;
    // Expected read result uses the register contents before this edge.
    exp_valid = re;
    if (re) begin
      exp_q.push_back({model_read(aa, we, ws, wd), model_read(ab, we, ws, wd)});
    end
    // Write / error rules.
    if (we) begin
      if ($countones(ws) != 1) begin
        exp_err = 1'b1;
      end else begin
        for (int i = 1; i < 32; i++) begin
          if (ws[i]) model_rf[i] = wd;
        end
        if (ce) exp_err = 1'b0;
      end
    end else if (ce) begin
      exp_err = 1'b0;
    end
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, '0, 1'b0, 5'd0, 5'd0, 1'b0);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [2*DATA_W-1:0] e;
    #1;
    if (rst_n) begin
      check("rd_valid", {31'd0, rd_valid}, {31'd0, exp_valid});
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rd_unexpected: got rd_valid=1 expected no read at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("rd_data_a", rd_data_a, e[2*DATA_W-1:DATA_W]);
          check("rd_data_b", rd_data_b, e[DATA_W-1:0]);
          hold_a = e[2*DATA_W-1:DATA_W];
          hold_b = e[DATA_W-1:0];
        end
      end else begin
        check("hold_a", rd_data_a, hold_a);
        check("hold_b", rd_data_b, hold_b);
      end
      check("sel_err", {31'd0, sel_err}, {31'd0, exp_err});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ws;
    int          kind;
    int          b0;
    int          b1;

    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    wr_en     = 1'b0;
    wr_sel    = '0;
    wr_data   = '0;
    rd_en     = 1'b0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    clr_err   = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #2;
    check("reset_rd_valid", {31'd0, rd_valid}, '0);
    check("reset_rd_data_a", rd_data_a, '0);
    check("reset_sel_err", {31'd0, sel_err}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Read after reset: r5 gives RESET_VAL, r0 gives 0.
    drive(1'b0, 32'd0, '0, 1'b1, 5'd5, 5'd0, 1'b0);
    // Write r5, read it back on both ports.
    drive(1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0, 1'b0);
    drive(1'b0, 32'd0, '0, 1'b1, 5'd5, 5'd5, 1'b0);
    // r0 write is discarded, no error.
    drive(1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd0, 1'b0);
    drive(1'b0, 32'd0, '0, 1'b1, 5'd0, 5'd0, 1'b0);
    // Two-hot select: no change to r8/r9, sticky error.
    drive(1'b1, 32'h0000_0300, 32'h1234_5678, 1'b0, 5'd0, 5'd0, 1'b0);
    drive(1'b0, 32'd0, '0, 1'b1, 5'd8, 5'd9, 1'b0);
    idle();
    drive(1'b0, 32'd0, '0, 1'b0, 5'd0, 5'd0, 1'b1);            // clear alone
    drive(1'b1, 32'h0000_0001, 32'd7, 1'b0, 5'd0, 5'd0, 1'b0); // r0, not an error
    drive(1'b1, 32'd0, 32'd1, 1'b0, 5'd0, 5'd0, 1'b1);         // error beats clear
    idle();
    drive(1'b0, 32'd0, '0, 1'b0, 5'd0, 5'd0, 1'b1);
    // Same-edge read/write of r7.
    drive(1'b1, 32'h0000_0080, 32'h1111_1111, 1'b0, 5'd0, 5'd0, 1'b0);
    drive(1'b1, 32'h0000_0080, 32'h2222_2222, 1'b1, 5'd7, 5'd7, 1'b0);
    drive(1'b0, 32'd0, '0, 1'b1, 5'd7, 5'd0, 1'b0);
    // Back-to-back reads.
    drive(1'b0, 32'd0, '0, 1'b1, 5'd5, 5'd7, 1'b0);
    drive(1'b0, 32'd0, '0, 1'b1, 5'd7, 5'd5, 1'b0);
    idle();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 5) begin
        ws = 32'd1 << $urandom_range(0, 31);
      end else if (kind == 6) begin
        ws = 32'd0;
      end else if (kind == 7) begin
        b0 = $urandom_range(0, 31);
        b1 = (b0 + $urandom_range(1, 31)) % 32;
        ws = (32'd1 << b0) | (32'd1 << b1);
      end else begin
        ws = $urandom;
      end
      drive(($urandom_range(0, 3) != 0), ws, $urandom,
            ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), ($urandom_range(0, 7) == 0));
    end
    idle();
    drive(1'b0, 32'd0, '0, 1'b0, 5'd0, 5'd0, 1'b1);

    // Asynchronous reset mid-cycle, right after a read result appears.
    drive(1'b1, 32'h0000_0008, 32'hA5A5_A5A5, 1'b0, 5'd0, 5'd0, 1'b0);
    drive(1'b0, 32'd0, '0, 1'b1, 5'd3, 5'd3, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    model_reset();
    #1;
    check("async_rst_rd_valid", {31'd0, rd_valid}, '0);
    check("async_rst_rd_data_a", rd_data_a, '0);
    check("async_rst_rd_data_b", rd_data_b, '0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'd0, '0, 1'b1, 5'd3, 5'd0, 1'b0);
    idle();
    idle();

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending reads expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
